// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with load-use hazard detection, stall and flush bubbles
//
// Optional feature macro: IDEX_STALL_COUNT_EN (adds stallCount_OUT / flushCount_OUT)
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   *FLAG_IN, aluOp_IN  decoded control flags from ID
//   PC_ADDR_IN          PC+4 from IF/ID
//   READ_DATA_1/2_IN    register file read ports
//   signExtImm_IN       sign-extended immediate
//   rs/rt/rd_IN         register fields of the instruction in ID
//   flush_IN            branch taken: squash the instruction in ID
//   *_OUT               registered copies of the inputs, presented to EX
//   valid_OUT           1 = real instruction in EX, 0 = bubble
//   stall_OUT           combinational: hold PC and IF/ID this cycle
//   stallCount_OUT      (optional) saturating count of stall cycles
//   flushCount_OUT      (optional) saturating count of flush cycles
module idex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regWriteFLAG_IN,
    input  logic                  memToRegFLAG_IN,
    input  logic                  branchFLAG_IN,
    input  logic [1:0]            memReadFLAG_IN,
    input  logic                  memWriteFLAG_IN,
    input  logic                  aluSrcFLAG_IN,
    input  logic                  regDstFLAG_IN,
    input  logic [1:0]            aluOp_IN,
    input  logic [DATA_W-1:0]     PC_ADDR_IN,
    input  logic [DATA_W-1:0]     READ_DATA_1_IN,
    input  logic [DATA_W-1:0]     READ_DATA_2_IN,
    input  logic [DATA_W-1:0]     signExtImm_IN,
    input  logic [REG_ADDR_W-1:0] rs_IN,
    input  logic [REG_ADDR_W-1:0] rt_IN,
    input  logic [REG_ADDR_W-1:0] rd_IN,
    input  logic                  flush_IN,
    output logic                  regWriteFLAG_OUT,
    output logic                  memToRegFLAG_OUT,
    output logic                  branchFLAG_OUT,
    output logic [1:0]            memReadFLAG_OUT,
    output logic                  memWriteFLAG_OUT,
    output logic                  aluSrcFLAG_OUT,
    output logic                  regDstFLAG_OUT,
    output logic [1:0]            aluOp_OUT,
    output logic [DATA_W-1:0]     PC_ADDR_OUT,
    output logic [DATA_W-1:0]     READ_DATA_1_OUT,
    output logic [DATA_W-1:0]     READ_DATA_2_OUT,
    output logic [DATA_W-1:0]     signExtImm_OUT,
    output logic [REG_ADDR_W-1:0] rs_OUT,
    output logic [REG_ADDR_W-1:0] rt_OUT,
    output logic [REG_ADDR_W-1:0] rd_OUT,
    output logic                  valid_OUT,
`ifdef IDEX_STALL_COUNT_EN
    output logic                  stall_OUT,
    output logic [15:0]           stallCount_OUT,
    output logic [15:0]           flushCount_OUT
`else
    output logic                  stall_OUT
`endif
);

    logic hazard;
    logic bubble;

    // A load in EX whose destination feeds the instruction in ID; $0 never counts.
    assign hazard = valid_OUT && (memReadFLAG_OUT != 2'b00) && (rt_OUT != '0) &&
                    ((rt_OUT == rs_IN) || (rt_OUT == rt_IN));
    // A flush discards the held instruction, so upstream must be free to redirect.
    assign stall_OUT = hazard & ~flush_IN & ~reset;
    assign bubble    = flush_IN | hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            regWriteFLAG_OUT <= 1'b0;
            memToRegFLAG_OUT <= 1'b0;
            branchFLAG_OUT   <= 1'b0;
            memReadFLAG_OUT  <= 2'b00;
            memWriteFLAG_OUT <= 1'b0;
            aluSrcFLAG_OUT   <= 1'b0;
            regDstFLAG_OUT   <= 1'b0;
            aluOp_OUT        <= 2'b00;
            PC_ADDR_OUT      <= '0;
            READ_DATA_1_OUT  <= '0;
            READ_DATA_2_OUT  <= '0;
            signExtImm_OUT   <= '0;
            rs_OUT           <= '0;
            rt_OUT           <= '0;
            rd_OUT           <= '0;
            valid_OUT        <= 1'b0;
        end else begin
            regWriteFLAG_OUT <= regWriteFLAG_IN & ~bubble;
            memToRegFLAG_OUT <= memToRegFLAG_IN & ~bubble;
            branchFLAG_OUT   <= branchFLAG_IN & ~bubble;
            memReadFLAG_OUT  <= bubble ? 2'b00 : memReadFLAG_IN;
            memWriteFLAG_OUT <= memWriteFLAG_IN & ~bubble;
            aluSrcFLAG_OUT   <= aluSrcFLAG_IN & ~bubble;
            regDstFLAG_OUT   <= regDstFLAG_IN & ~bubble;
            aluOp_OUT        <= bubble ? 2'b00 : aluOp_IN;
            // Data fields are don't-care in a bubble; loading them keeps the path simple.
            PC_ADDR_OUT      <= PC_ADDR_IN;
            READ_DATA_1_OUT  <= READ_DATA_1_IN;
            READ_DATA_2_OUT  <= READ_DATA_2_IN;
            signExtImm_OUT   <= signExtImm_IN;
            rs_OUT           <= rs_IN;
            rt_OUT           <= rt_IN;
            rd_OUT           <= rd_IN;
            valid_OUT        <= ~bubble;
        end
    end

`ifdef IDEX_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount_OUT <= 16'h0000;
            flushCount_OUT <= 16'h0000;
        end else begin
            if (stall_OUT && stallCount_OUT != 16'hFFFF)
                stallCount_OUT <= stallCount_OUT + 16'd1;
            if (flush_IN && flushCount_OUT != 16'hFFFF)
                flushCount_OUT <= flushCount_OUT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: scoreboard bench for idex_stage (reset, load-use stall, flush priority, random traffic)
module tb_idex_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        br;
        logic [1:0]  mr;
        logic        mw;
        logic        as;
        logic        rds;
        logic [1:0]  op;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } in_t;

    typedef struct packed {
        in_t  f;
        logic v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    in_t  drv;

    logic        regWriteFLAG_OUT, memToRegFLAG_OUT, branchFLAG_OUT;
    logic [1:0]  memReadFLAG_OUT;
    logic        memWriteFLAG_OUT, aluSrcFLAG_OUT, regDstFLAG_OUT;
    logic [1:0]  aluOp_OUT;
    logic [31:0] PC_ADDR_OUT, READ_DATA_1_OUT, READ_DATA_2_OUT, signExtImm_OUT;
    logic [4:0]  rs_OUT, rt_OUT, rd_OUT;
    logic        valid_OUT, stall_OUT;
`ifdef IDEX_STALL_COUNT_EN
    logic [15:0] stallCount_OUT, flushCount_OUT;
    logic [15:0] sc, fc;
`endif

    exp_t got;
    assign got = {regWriteFLAG_OUT, memToRegFLAG_OUT, branchFLAG_OUT, memReadFLAG_OUT,
                  memWriteFLAG_OUT, aluSrcFLAG_OUT, regDstFLAG_OUT, aluOp_OUT,
                  PC_ADDR_OUT, READ_DATA_1_OUT, READ_DATA_2_OUT, signExtImm_OUT,
                  rs_OUT, rt_OUT, rd_OUT, valid_OUT};

    idex_stage dut (
        .clk(clk), .reset(reset),
        .regWriteFLAG_IN(drv.rw), .memToRegFLAG_IN(drv.m2r), .branchFLAG_IN(drv.br),
        .memReadFLAG_IN(drv.mr), .memWriteFLAG_IN(drv.mw), .aluSrcFLAG_IN(drv.as),
        .regDstFLAG_IN(drv.rds), .aluOp_IN(drv.op), .PC_ADDR_IN(drv.pc),
        .READ_DATA_1_IN(drv.d1), .READ_DATA_2_IN(drv.d2), .signExtImm_IN(drv.imm),
        .rs_IN(drv.rs), .rt_IN(drv.rt), .rd_IN(drv.rd), .flush_IN(flush),
        .regWriteFLAG_OUT(regWriteFLAG_OUT), .memToRegFLAG_OUT(memToRegFLAG_OUT),
        .branchFLAG_OUT(branchFLAG_OUT), .memReadFLAG_OUT(memReadFLAG_OUT),
        .memWriteFLAG_OUT(memWriteFLAG_OUT), .aluSrcFLAG_OUT(aluSrcFLAG_OUT),
        .regDstFLAG_OUT(regDstFLAG_OUT), .aluOp_OUT(aluOp_OUT),
        .PC_ADDR_OUT(PC_ADDR_OUT), .READ_DATA_1_OUT(READ_DATA_1_OUT),
        .READ_DATA_2_OUT(READ_DATA_2_OUT), .signExtImm_OUT(signExtImm_OUT),
        .rs_OUT(rs_OUT), .rt_OUT(rt_OUT), .rd_OUT(rd_OUT), .valid_OUT(valid_OUT),
`ifdef IDEX_STALL_COUNT_EN
        .stallCount_OUT(stallCount_OUT), .flushCount_OUT(flushCount_OUT),
`endif
        .stall_OUT(stall_OUT)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t m;
    logic st;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] req);
        checks++;
        if (obs !== req) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, req);
        end
    endtask

    function automatic in_t mk(input logic [1:0] mr, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd);
        in_t t;
        t.rw  = 1'($urandom);
        t.m2r = 1'($urandom);
        t.br  = 1'($urandom);
        t.mr  = mr;
        t.mw  = 1'($urandom);
        t.as  = 1'($urandom);
        t.rds = 1'($urandom);
        t.op  = 2'($urandom);
        t.pc  = $urandom;
        t.d1  = $urandom;
        t.d2  = $urandom;
        t.imm = $urandom;
        t.rs  = rs;
        t.rt  = rt;
        t.rd  = rd;
        return t;
    endfunction

    // Drive one ID-stage cycle, check stall against the model, then check the registered result.
    task automatic step(input in_t i, input logic fl, input logic rst);
        logic h, se;
        exp_t n, e;
        @(negedge clk);
        drv = i;
        flush = fl;
        reset = rst;
        #1;
        h  = m.v && (m.f.mr != 2'b00) && (m.f.rt != 5'd0) && (m.f.rt == i.rs || m.f.rt == i.rt);
        se = h && !fl && !rst;
        st = stall_OUT;
        check("stall", 160'(stall_OUT), 160'(se));
        if (rst) begin
            n = '0;
        end else begin
            n.f = i;
            n.v = !(fl || h);
            if (fl || h) begin
                {n.f.rw, n.f.m2r, n.f.br, n.f.mr, n.f.mw, n.f.as, n.f.rds, n.f.op} = '0;
            end
        end
`ifdef IDEX_STALL_COUNT_EN
        if (rst) begin
            sc = 16'h0;
            fc = 16'h0;
        end else begin
            if (se && sc != 16'hFFFF) sc = sc + 16'd1;
            if (fl && fc != 16'hFFFF) fc = fc + 16'd1;
        end
`endif
        q.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("regs", 160'(got), 160'(e));
`ifdef IDEX_STALL_COUNT_EN
        check("stall_cnt", 160'(stallCount_OUT), 160'(sc));
        check("flush_cnt", 160'(flushCount_OUT), 160'(fc));
`endif
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t t;
        m = '0;
        drv = '0;
        flush = 1'b0;
        reset = 1'b1;
`ifdef IDEX_STALL_COUNT_EN
        sc = 16'h0;
        fc = 16'h0;
`endif
        // Reset with random inputs
        step(mk(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)), 1'($urandom), 1'b1);
        step(mk(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)), 1'($urandom), 1'b1);
        check("rst_all_zero", 160'(got), 160'(0));
        check("rst_stall", 160'(st), 160'(0));

        // First instruction after reset
        t = mk(2'b00, 5'd1, 5'd2, 5'd8);
        t.rw = 1'b1;
        step(t, 1'b0, 1'b0);
        check("first_rw", 160'(regWriteFLAG_OUT), 160'(1));
        check("first_rd", 160'(rd_OUT), 160'(8));
        check("first_valid", 160'(valid_OUT), 160'(1));

        // Load-use: load rt=9, consumer rs=9 stalls once, then is captured
        step(mk(2'b01, 5'd3, 5'd9, 5'd4), 1'b0, 1'b0);
        t = mk(2'b00, 5'd9, 5'd12, 5'd13);
        step(t, 1'b0, 1'b0);
        check("ldu_stall", 160'(st), 160'(1));
        check("ldu_bubble_valid", 160'(valid_OUT), 160'(0));
        check("ldu_bubble_flags", 160'({regWriteFLAG_OUT, memToRegFLAG_OUT, branchFLAG_OUT,
              memReadFLAG_OUT, memWriteFLAG_OUT, aluSrcFLAG_OUT, regDstFLAG_OUT, aluOp_OUT}), 160'(0));
        step(t, 1'b0, 1'b0);
        check("ldu_release", 160'(st), 160'(0));
        check("ldu_rs", 160'(rs_OUT), 160'(9));
        check("ldu_valid", 160'(valid_OUT), 160'(1));

        // No false stalls
        step(mk(2'b01, 5'd3, 5'd9, 5'd4), 1'b0, 1'b0);
        step(mk(2'b00, 5'd10, 5'd11, 5'd4), 1'b0, 1'b0);
        check("nostall_diff", 160'(st), 160'(0));
        step(mk(2'b10, 5'd3, 5'd0, 5'd4), 1'b0, 1'b0);
        step(mk(2'b00, 5'd0, 5'd5, 5'd4), 1'b0, 1'b0);
        check("nostall_r0", 160'(st), 160'(0));
        step(mk(2'b00, 5'd3, 5'd9, 5'd4), 1'b0, 1'b0);
        step(mk(2'b00, 5'd9, 5'd5, 5'd4), 1'b0, 1'b0);
        check("nostall_noload", 160'(st), 160'(0));

        // Flush beats hazard
        step(mk(2'b01, 5'd3, 5'd9, 5'd4), 1'b0, 1'b0);
        t = mk(2'b00, 5'd9, 5'd5, 5'd4);
        t.mw = 1'b1;
        step(t, 1'b1, 1'b0);
        check("flush_stall", 160'(st), 160'(0));
        check("flush_mw", 160'(memWriteFLAG_OUT), 160'(0));
        check("flush_valid", 160'(valid_OUT), 160'(0));

        // Back-to-back loads: each dependent consumer stalls once
        step(mk(2'b01, 5'd3, 5'd9, 5'd4), 1'b0, 1'b0);
        t = mk(2'b11, 5'd9, 5'd10, 5'd4);
        step(t, 1'b0, 1'b0);
        check("b2b_stall1", 160'(st), 160'(1));
        step(t, 1'b0, 1'b0);
        check("b2b_capture", 160'(memReadFLAG_OUT), 160'(3));
        step(mk(2'b00, 5'd10, 5'd6, 5'd4), 1'b0, 1'b0);
        check("b2b_stall2", 160'(st), 160'(1));

        // Reset during a stall cycle
        step(mk(2'b00, 5'd10, 5'd6, 5'd4), 1'b0, 1'b0);
        step(mk(2'b01, 5'd3, 5'd9, 5'd4), 1'b0, 1'b0);
        step(mk(2'b00, 5'd9, 5'd5, 5'd4), 1'b0, 1'b1);
        check("rst_mid_stall", 160'(st), 160'(0));
        check("rst_mid_zero", 160'(got), 160'(0));

        // Random traffic over a small register window to provoke hazards
        for (int k = 0; k < 300; k++)
            step(mk(2'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);

`ifdef IDEX_STALL_COUNT_EN
        // Three load-use stalls and two flushes from a clean reset
        step(mk(2'b00, 5'd1, 5'd2, 5'd3), 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(mk(2'b01, 5'd3, 5'd9, 5'd4), 1'b0, 1'b0);
            t = mk(2'b00, 5'd9, 5'd5, 5'd4);
            step(t, 1'b0, 1'b0);
            step(t, 1'b0, 1'b0);
        end
        step(mk(2'b00, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
        step(mk(2'b00, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
        check("cnt_stall3", 160'(stallCount_OUT), 160'(3));
        check("cnt_flush2", 160'(flushCount_OUT), 160'(2));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath. Sits between the decode stage (after IF/ID) and EX, and feeds the EX/MEM register.
- Captures decoded control flags, operands, immediate, PC and register addresses every cycle.
- Integrates load-use hazard detection: it stalls fetch/decode and inserts a bubble.
- Supports a flush (bubble insertion) when a branch is taken.

Parameters:
DATA_W, 32, width of data/PC/immediate paths
REG_ADDR_W, 5, register address width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
regWriteFLAG_IN  input  1  decoded register-write enable
memToRegFLAG_IN  input  1  writeback mux select
branchFLAG_IN  input  1  branch instruction
memReadFLAG_IN  input  2  load type; 0 = no load
memWriteFLAG_IN  input  1  store
aluSrcFLAG_IN  input  1  ALU B-operand select
regDstFLAG_IN  input  1  destination select (rd vs rt)
aluOp_IN  input  2  ALU control class
PC_ADDR_IN  input  DATA_W  PC+4 from IF/ID
READ_DATA_1_IN  input  DATA_W  register file port 1
READ_DATA_2_IN  input  DATA_W  register file port 2
signExtImm_IN  input  DATA_W  sign-extended immediate
rs_IN, rt_IN, rd_IN  input  REG_ADDR_W  register fields of the instruction in ID
flush_IN  input  1  branch taken; squash the instruction in ID
*_OUT (one per *_IN above)  output  same width as input  registered copies
valid_OUT  output  1  1 = real instruction in EX, 0 = bubble
stall_OUT  output  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset (synchronous, active-high):
  - At the clock edge with reset=1, every registered output clears to 0, including valid_OUT.
  - stall_OUT is 0 while reset=1.
  - Reset overrides flush and stall.
- Hazard condition H, combinational:
  - H = valid_OUT & (memReadFLAG_OUT != 0) & (rt_OUT != 0) & ((rt_OUT == rs_IN) | (rt_OUT == rt_IN)).
- stall_OUT = H & ~flush_IN & ~reset.
- At each rising edge, priority is reset > flush_IN > H > normal:
  - Flush: load a bubble.
  - H: load a bubble. The instruction in ID is not captured; upstream holds it because stall_OUT=1.
  - Normal: capture all *_IN into *_OUT; valid_OUT <= 1.
- Bubble definition:
  - Cleared: regWrite, memToReg, branch, memRead, memWrite, aluSrc, regDst, aluOp, and valid_OUT.
  - The data/address fields (PC, read data, immediate, rs/rt/rd) are still loaded from the inputs; they are don't-care once the flags are cleared.
- Latency:
  - Normally 1 cycle from ID to EX.
  - A load-use hazard costs exactly 1 bubble. After the bubble, memReadFLAG_OUT = 0, so H drops and the held instruction is captured on the next edge.
- Back-to-back loads:
  - A load whose source matches the previous load's rt stalls once.
  - The second load then causes its own stall for its dependent consumer.
- Flush during a stall cycle:
  - The bubble is inserted and stall_OUT = 0, so upstream is free to redirect.
  - The held instruction is discarded.
- Register $0 (rt_OUT == 0) never triggers a stall.

Optional Feature:
- Macro IDEX_STALL_COUNT_EN.
- When defined, two extra outputs exist:
  - stallCount_OUT [15:0]: increments on each edge where stall_OUT=1.
  - flushCount_OUT [15:0]: increments on each edge where flush_IN=1 and reset=0.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Reset check: reset=1 for 2 cycles with random inputs -> all *_OUT=0, valid_OUT=0, stall_OUT=0. On release, first edge with regWriteFLAG_IN=1, rd_IN=5'd8 -> regWriteFLAG_OUT=1, rd_OUT=8, valid_OUT=1.
- Load-use stall: load with memReadFLAG_IN=2'b01, rt_IN=9 captured; next ID has rs_IN=9:
  - stall_OUT=1 in that cycle, and the next edge yields a bubble with valid_OUT=0 and all flags 0.
  - The following cycle stall_OUT=0 and the consumer is captured with rs_OUT=9.
- No false stall:
  - Load rt=9 followed by an instruction with rs=10, rt=11 -> stall_OUT=0.
  - Load rt=0 followed by rs=0 -> stall_OUT=0.
  - Non-load (memRead=0) with rt=9 followed by rs=9 -> stall_OUT=0.
- Flush priority: hazard condition active and flush_IN=1 in the same cycle -> stall_OUT=0; the next edge yields a bubble with memWriteFLAG_OUT=0 and valid_OUT=0.
- Reset mid-stall: assert reset during a stall cycle -> stall_OUT=0 immediately and all outputs 0 after the edge.
- With IDEX_STALL_COUNT_EN defined:
  - 3 load-use stalls and 2 flushes -> stallCount_OUT=3, flushCount_OUT=2.
  - Counter preloaded near the top via 65537 forced stalls -> stallCount_OUT holds at 16'hFFFF.
